// File: rtl/wlo_mon_pkg.sv
// wlo_mon_pkg: monitor FSM states, drain length and saturation helpers
package wlo_mon_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam int DRAIN_CYC = 3;
  function automatic logic signed [127:0] sat_s(input logic signed [127:0] v, input int w);
    logic signed [127:0] hi, lo;
    hi = (128'sd1 <<< (w - 1)) - 128'sd1;
    lo = -hi - 128'sd1;
    return v > hi ? hi : v < lo ? lo : v;
  endfunction
  function automatic logic [127:0] sat_u(input logic [127:0] v, input int w);
    logic [127:0] hi;
    hi = (128'd1 << w) - 128'd1;
    return v > hi ? hi : v;
  endfunction
endpackage

// File: rtl/wlo_fx_align.sv
// wlo_fx_align: aligns signed x with frac_in fractional bits to FRAC_OUT fractional bits (x in, frac_in in, y out); ERRMON_ROUND_EN rounds right shifts half up
module wlo_fx_align #(
  parameter int IN_W = 29,
  parameter int FRAC_OUT = 16,
  parameter int OUT_W = IN_W + FRAC_OUT
) (
  input  logic signed [IN_W-1:0]  x,
  input  logic        [7:0]       frac_in,
  output logic signed [OUT_W-1:0] y
);
  localparam logic signed [8:0] IW = 9'(IN_W);
  logic signed [8:0] d;
  logic signed [OUT_W-1:0] xe, xr, fill;
  always_comb begin
    d = $signed({1'b0, frac_in}) - $signed(9'(FRAC_OUT));
    xe = OUT_W'(x);
`ifdef ERRMON_ROUND_EN
    xr = xe + (OUT_W'(1) <<< (5'(d) - 5'd1));
    fill = '0;
`else
    xr = xe;
    fill = {OUT_W{x[IN_W-1]}};
`endif
    y = d <= 9'sd0 ? xe <<< 5'(-d) : d < IW ? xr >>> 5'(d) : fill;
  end
endmodule

// File: rtl/wlo_err_monitor.sv
// wlo_err_monitor: pairs c with LAT-delayed ref, reports frame sse/max_abs_err/sample_cnt/pair_err with busy/done; ERRMON_ROUND_EN selects rounding alignment
module wlo_err_monitor
  import wlo_mon_pkg::*;
#(
  parameter int C_W = 29,
  parameter int REF_W = 32,
  parameter int REF_FRAC = 16,
  parameter int LAT = 4,
  parameter int ERR_W = 32,
  parameter int ACC_W = 64,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  input  logic [CNT_W-1:0]        frame_len,
  input  logic [7:0]              num_frac_c,
  input  logic                    c_valid,
  input  logic signed [C_W-1:0]   c,
  input  logic                    ref_valid,
  input  logic signed [REF_W-1:0] ref_data,
  output logic                    busy,
  output logic                    done,
  output logic [ACC_W-1:0]        sse,
  output logic [ERR_W-1:0]        max_abs_err,
  output logic [CNT_W-1:0]        sample_cnt,
  output logic                    pair_err
);
  localparam int AL_W = C_W + REF_FRAC;
  localparam int DLW = LAT * REF_W;
  localparam logic signed [ERR_W-1:0] EMAX = {1'b0, {(ERR_W-1){1'b1}}};
  state_t state_q, state_d;
  logic [LAT-1:0] rv_q, rv_d;
  logic [LAT-1:0][REF_W-1:0] rd_q, rd_d;
  logic [CNT_W-1:0] flen_q, flen_d, acc_q, acc_d, cnt_q, cnt_d;
  logic [1:0] drn_q, drn_d;
  logic perr_q, perr_d, v1_q, v1_d, v2_q, v2_d;
  logic signed [AL_W-1:0] al, al_q, al_d;
  logic signed [REF_W-1:0] r1_q, r1_d;
  logic signed [ERR_W-1:0] err_q, err_d;
  logic signed [2*ERR_W-1:0] sq;
  logic [ERR_W-1:0] abs_err, max_q, max_d;
  logic [ACC_W-1:0] sse_q, sse_d;
  logic dv, acc_en, upd;
  wlo_fx_align #(.IN_W(C_W), .FRAC_OUT(REF_FRAC)) u_align (
    .x(c),
    .frac_in(num_frac_c),
    .y(al)
  );
  always_comb begin
    dv = rv_q[LAT-1];
    acc_en = state_q == RUN && !start && c_valid && dv && acc_q != flen_q;
    rv_d = LAT'({rv_q, ref_valid});
    rd_d = DLW'({rd_q, ref_data});
    v1_d = acc_en;
    al_d = al;
    r1_d = rd_q[LAT-1];
    v2_d = v1_q && !start;
    err_d = ERR_W'(sat_s(128'(r1_q) - 128'(al_q), ERR_W));
    sq = err_q * err_q;
    abs_err = err_q[ERR_W-1] ? (err_q == ~EMAX ? EMAX : -err_q) : err_q;
    upd = v2_q && !start;
    sse_d = start ? '0 : upd ? ACC_W'(sat_u(128'(sse_q) + 128'(sq), ACC_W)) : sse_q;
    max_d = start ? '0 : upd && abs_err > max_q ? abs_err : max_q;
    cnt_d = start ? '0 : cnt_q + CNT_W'(upd);
    acc_d = start ? '0 : acc_q + CNT_W'(acc_en);
    flen_d = start ? frame_len : flen_q;
    perr_d = !start && (perr_q || (state_q == RUN && c_valid && !dv));
    drn_d = state_q == DRAIN && !start ? drn_q + 2'd1 : '0;
    state_d = start ? RUN
            : state_q == RUN ? (acc_d == flen_q ? DRAIN : RUN)
            : state_q == DRAIN && drn_q == 2'(DRAIN_CYC - 1) ? DONE : state_q;
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      rv_q <= '0;
      rd_q <= '0;
      flen_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      drn_q <= '0;
      perr_q <= 1'b0;
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      al_q <= '0;
      r1_q <= '0;
      err_q <= '0;
      max_q <= '0;
      sse_q <= '0;
    end else begin
      state_q <= state_d;
      rv_q <= rv_d;
      rd_q <= rd_d;
      flen_q <= flen_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      drn_q <= drn_d;
      perr_q <= perr_d;
      v1_q <= v1_d;
      v2_q <= v2_d;
      al_q <= al_d;
      r1_q <= r1_d;
      err_q <= err_d;
      max_q <= max_d;
      sse_q <= sse_d;
    end
  end
  assign busy = state_q == RUN || state_q == DRAIN;
  assign done = state_q == DONE;
  assign sse = sse_q;
  assign max_abs_err = max_q;
  assign sample_cnt = cnt_q;
  assign pair_err = perr_q;
endmodule
